// File: rtl/pes_tlc_sensor_ctrl.sv
// Farm-road sensor front-end for the pes_tlc traffic-light FSM: synchronise, debounce,
// latch arrivals, and hold car_req until highway green has run its minimum time.
module pes_tlc_sensor_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned MIN_GREEN   = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic [2:0]       light_highway,
  output logic             car_req,
  output logic             sensor_db,
  output logic [CNT_W-1:0] green_cnt,
  output logic [7:0]       veh_count,
  output logic             req_pending
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX = CNT_W'(MIN_GREEN);

  typedef enum logic [1:0] {StIdle, StPend, StReq, StAck} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   db_q, db_d;
  logic                   db_prev_q;
  logic [CNT_W-1:0]       green_q, green_d;
  logic [7:0]             veh_q, veh_d;
  logic                   rearm_q, rearm_d;
  logic                   car_req_q;

  logic s_sync, arrival, hw_green, min_ok;

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign arrival  = db_q & ~db_prev_q;
  assign hw_green = (light_highway == 3'b001);
  assign min_ok   = (green_q == GREEN_MAX);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sensor_raw};
    deb_cnt_d = '0;
    db_d      = db_q;
    if (s_sync != db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        db_d = ~db_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end

    veh_d = veh_q;
    if (arrival && veh_q != 8'hff) begin
      veh_d = veh_q + 8'd1;
    end

    green_d = '0;
    if (hw_green) begin
      green_d = min_ok ? green_q : green_q + CNT_W'(1);
    end
  end

  // Re-arm only accumulates inside ACK; sensor_db is sampled at the moment green returns.
  always_comb begin
    state_d = state_q;
    rearm_d = 1'b0;
    unique case (state_q)
      StIdle: if (arrival) state_d = StPend;
      StPend: if (hw_green && min_ok) state_d = StReq;
      StReq:  if (!hw_green) state_d = StAck;
      StAck: begin
        rearm_d = rearm_q | arrival;
        if (hw_green) begin
          state_d = (rearm_q || arrival || db_q) ? StPend : StIdle;
          rearm_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      deb_cnt_q <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      green_q   <= '0;
      veh_q     <= '0;
      rearm_q   <= 1'b0;
      car_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      green_q   <= green_d;
      veh_q     <= veh_d;
      rearm_q   <= rearm_d;
      car_req_q <= (state_d == StReq);
    end
  end

  assign car_req     = car_req_q;
  assign sensor_db   = db_q;
  assign green_cnt   = green_q;
  assign veh_count   = veh_q;
  assign req_pending = (state_q == StPend) || (state_q == StReq) ||
                       ((state_q == StAck) && rearm_q);

endmodule

// File: tb/tb_pes_tlc_sensor_ctrl.sv
// Directed bench for pes_tlc_sensor_ctrl with default parameters (DEB 16, MIN_GREEN 64).
module tb_pes_tlc_sensor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_raw;
  logic [2:0] light_highway;
  logic       car_req;
  logic       sensor_db;
  logic [7:0] green_cnt;
  logic [7:0] veh_count;
  logic       req_pending;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] Green  = 3'b001;
  localparam logic [2:0] Yellow = 3'b010;
  localparam logic [2:0] Red    = 3'b100;

  pes_tlc_sensor_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_raw   (sensor_raw),
    .light_highway(light_highway),
    .car_req      (car_req),
    .sensor_db    (sensor_db),
    .green_cnt    (green_cnt),
    .veh_count    (veh_count),
    .req_pending  (req_pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    sensor_raw = 1'b0;
    light_highway = Red;
    tick(3);
    chk("rst_car_req", car_req, 0);
    chk("rst_sensor_db", sensor_db, 0);
    chk("rst_green_cnt", green_cnt, 0);
    chk("rst_veh_count", veh_count, 0);
    chk("rst_req_pending", req_pending, 0);
    rst = 1'b0;
    tick(2);

    // Glitch of 10 cycles is filtered
    sensor_raw = 1'b1;
    tick(10);
    sensor_raw = 1'b0;
    tick(30);
    chk("glitch_db", sensor_db, 0);
    chk("glitch_veh", veh_count, 0);
    chk("glitch_car_req", car_req, 0);
    chk("glitch_pending", req_pending, 0);

    // Held sensor: sensor_db rises 18 edges after the raw edge
    sensor_raw = 1'b1;
    tick(17);
    chk("hold_db_early", sensor_db, 0);
    tick(1);
    chk("hold_db_rise", sensor_db, 1);
    chk("hold_veh_before", veh_count, 0);
    tick(1);
    chk("hold_veh", veh_count, 1);
    chk("hold_pending", req_pending, 1);
    chk("hold_car_req_red", car_req, 0);
    tick(21);
    sensor_raw = 1'b0;
    tick(20);
    chk("hold_db_fall", sensor_db, 0);
    chk("hold_veh_stable", veh_count, 1);
    chk("hold_still_pend", req_pending, 1);

    // PEND with highway going green from red
    light_highway = Green;
    tick(63);
    chk("pend_green63", green_cnt, 63);
    chk("pend_car_req63", car_req, 0);
    tick(1);
    chk("pend_green64", green_cnt, 64);
    chk("pend_car_req64", car_req, 0);
    tick(1);
    chk("pend_car_req_rise", car_req, 1);
    light_highway = Yellow;
    tick(1);
    chk("req_drop_yellow", car_req, 0);
    chk("yellow_green_clr", green_cnt, 0);
    chk("ack_no_rearm", req_pending, 0);
    light_highway = Green;
    tick(1);
    chk("ack_to_idle", req_pending, 0);
    chk("idle_green1", green_cnt, 1);

    // Early arrival: arrival lands at green_cnt=10
    light_highway = Red;
    sensor_raw = 1'b1;
    tick(9);
    light_highway = Green;
    tick(10);
    chk("early_green10", green_cnt, 10);
    chk("early_veh", veh_count, 2);
    chk("early_pending", req_pending, 1);
    chk("early_car_req0", car_req, 0);
    tick(54);
    chk("early_green64", green_cnt, 64);
    chk("early_car_req_hold", car_req, 0);
    tick(1);
    chk("early_car_req_rise", car_req, 1);
    light_highway = Yellow;
    tick(1);
    chk("early_car_req_fall", car_req, 0);
    // Return to green with sensor_db still high re-arms PEND
    light_highway = Green;
    tick(1);
    chk("return_db_pend", req_pending, 1);
    chk("return_car_req", car_req, 0);
    chk("return_green_restart", green_cnt, 1);
    tick(63);
    chk("return_car_req_wait", car_req, 0);
    tick(1);
    chk("return_car_req_rise", car_req, 1);

    // Asynchronous reset while in REQ
    rst = 1'b1;
    sensor_raw = 1'b0;
    #1;
    chk("arst_car_req", car_req, 0);
    chk("arst_green", green_cnt, 0);
    chk("arst_veh", veh_count, 0);
    chk("arst_db", sensor_db, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("arst_idle", req_pending, 0);

    // Late arrival: green already saturated
    tick(63);
    chk("late_green64", green_cnt, 64);
    chk("late_idle_car_req", car_req, 0);
    sensor_raw = 1'b1;
    tick(18);
    chk("late_db", sensor_db, 1);
    chk("late_car_req0", car_req, 0);
    tick(1);
    chk("late_pending", req_pending, 1);
    chk("late_car_req_pend", car_req, 0);
    tick(1);
    chk("late_car_req_rise", car_req, 1);
    light_highway = Yellow;
    tick(1);
    chk("late_car_req_fall", car_req, 0);

    // Arrival during ACK re-arms even if sensor_db has fallen by the return
    sensor_raw = 1'b0;
    tick(20);
    chk("ack_db_low", sensor_db, 0);
    chk("ack_pending_low", req_pending, 0);
    sensor_raw = 1'b1;
    tick(19);
    chk("ack_arrival_veh", veh_count, 2);
    chk("ack_rearm_pending", req_pending, 1);
    sensor_raw = 1'b0;
    tick(20);
    chk("ack_db_low2", sensor_db, 0);
    light_highway = Green;
    tick(1);
    chk("ack_rearm_pend", req_pending, 1);
    chk("ack_rearm_car_req", car_req, 0);

    // Saturation of veh_count and green_cnt
    for (int i = 0; i < 250; i++) begin
      sensor_raw = 1'b1;
      tick(20);
      sensor_raw = 1'b0;
      tick(20);
    end
    chk("sat_veh252", veh_count, 252);
    for (int i = 0; i < 50; i++) begin
      sensor_raw = 1'b1;
      tick(20);
      sensor_raw = 1'b0;
      tick(20);
    end
    chk("sat_veh255", veh_count, 255);
    chk("sat_green64", green_cnt, 64);
    chk("sat_car_req", car_req, 1);
    light_highway = Red;
    tick(1);
    chk("red_green_clr", green_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
